// File: rtl/kb_pkg.sv
`default_nettype none
// kb_pkg -- PS/2 set-2 scan-code constants, prefix FSM encoding and make-code to ASCII map.
// rev 1.0
package kb_pkg;

  localparam logic [7:0] SC_EXT    = 8'hE0;
  localparam logic [7:0] SC_BRK    = 8'hF0;
  localparam logic [7:0] SC_LSHIFT = 8'h12;
  localparam logic [7:0] SC_RSHIFT = 8'h59;
  localparam logic [7:0] SC_CAPS   = 8'h58;
  localparam logic [7:0] SC_NUM    = 8'h77;
  localparam logic [7:0] SC_SCROLL = 8'h7E;
  localparam logic [7:0] SC_SPACE  = 8'h29;
  localparam logic [7:0] SC_ENTER  = 8'h5A;
  localparam logic [7:0] SC_BKSP   = 8'h66;

  localparam logic [1:0] ST_BASE    = 2'd0;
  localparam logic [1:0] ST_EXT     = 2'd1;
  localparam logic [1:0] ST_BRK     = 2'd2;
  localparam logic [1:0] ST_EXT_BRK = 2'd3;

  localparam int LED_SCROLL = 0;
  localparam int LED_NUM    = 1;
  localparam int LED_CAPS   = 2;

  // Returns {char_valid, ascii}; letters are mapped lowercase then folded to upper.
  function automatic logic [8:0] kb_translate(input logic [7:0] code,
                                              input logic       shift,
                                              input logic       caps);
    logic [7:0] ch;
    logic       letter;
    logic       ok;
    ch     = 8'h00;
    letter = 1'b1;
    ok     = 1'b1;
    case (code)
      8'h1C: ch = 8'h61; 8'h32: ch = 8'h62; 8'h21: ch = 8'h63; 8'h23: ch = 8'h64;
      8'h24: ch = 8'h65; 8'h2B: ch = 8'h66; 8'h34: ch = 8'h67; 8'h33: ch = 8'h68;
      8'h43: ch = 8'h69; 8'h3B: ch = 8'h6A; 8'h42: ch = 8'h6B; 8'h4B: ch = 8'h6C;
      8'h3A: ch = 8'h6D; 8'h31: ch = 8'h6E; 8'h44: ch = 8'h6F; 8'h4D: ch = 8'h70;
      8'h15: ch = 8'h71; 8'h2D: ch = 8'h72; 8'h1B: ch = 8'h73; 8'h2C: ch = 8'h74;
      8'h3C: ch = 8'h75; 8'h2A: ch = 8'h76; 8'h1D: ch = 8'h77; 8'h22: ch = 8'h78;
      8'h35: ch = 8'h79; 8'h1A: ch = 8'h7A;
      default: letter = 1'b0;
    endcase
    if (letter) begin
      if (shift ^ caps) ch = ch - 8'h20;
    end else begin
      case (code)
        8'h16: ch = shift ? 8'h21 : 8'h31;
        8'h1E: ch = shift ? 8'h40 : 8'h32;
        8'h26: ch = shift ? 8'h23 : 8'h33;
        8'h25: ch = shift ? 8'h24 : 8'h34;
        8'h2E: ch = shift ? 8'h25 : 8'h35;
        8'h36: ch = shift ? 8'h5E : 8'h36;
        8'h3D: ch = shift ? 8'h26 : 8'h37;
        8'h3E: ch = shift ? 8'h2A : 8'h38;
        8'h46: ch = shift ? 8'h28 : 8'h39;
        8'h45: ch = shift ? 8'h29 : 8'h30;
        SC_SPACE: ch = 8'h20;
        SC_ENTER: ch = 8'h0D;
        SC_BKSP:  ch = 8'h08;
        default:  ok = 1'b0;
      endcase
    end
    return {ok, ch};
  endfunction

endpackage
`default_nettype wire

// File: rtl/kb_char_fifo.sv
`default_nettype none
// kb_char_fifo -- show-ahead character FIFO with sticky overflow; full FIFO accepts push+pop together.
// rev 1.0
module kb_char_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       push_i,
  input  logic [7:0] data_i,
  input  logic       pop_i,
  output logic [7:0] data_o,
  output logic       valid_o,
  output logic       overflow_o
);

  localparam int            AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]   C_DEPTH = (AW + 1)'(FIFO_DEPTH);
  localparam logic [AW:0]   C_ONE   = (AW + 1)'(1);

  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, do_pop, do_push;

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == C_DEPTH);
  assign do_pop  = pop_i && !empty;
  // A pop frees the slot this same edge, so a full FIFO can still take the push.
  assign do_push = push_i && (!full || do_pop);

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    if (do_pop)  rd_d = rd_q + AW'(1);
    if (do_push) wr_d = wr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + C_ONE;
      2'b01:   cnt_d = cnt_q - C_ONE;
      default: cnt_d = cnt_q;
    endcase
    if (push_i && !do_push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push && !rst_i) mem_q[wr_q] <= data_i;
  end

  assign valid_o    = !empty;
  assign data_o     = empty ? 8'h00 : mem_q[rd_q];
  assign overflow_o = ovf_q;

endmodule
`default_nettype wire

// File: rtl/kb_decoder.sv
`default_nettype none
// kb_decoder -- PS/2 set-2 prefix FSM, modifier/lock tracking and ASCII translation into a FIFO.
// rev 1.0
module kb_decoder
  import kb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic [7:0] i_keycode,
  input  logic       i_ready,
  output logic [2:0] o_led_status,
  output logic [7:0] o_ascii,
  output logic       o_valid,
  input  logic       i_pop,
  output logic       o_overflow
);

  logic [1:0] state_q, state_d;
  logic       lshift_q, lshift_d, rshift_q, rshift_d;
  logic       caps_held_q, caps_held_d, num_held_q, num_held_d, scroll_held_q, scroll_held_d;
  logic [2:0] led_q, led_d;

  logic       is_prefix, make_ev, brk_ev, char_push;
  logic [8:0] xlat;

  assign is_prefix = (i_keycode == SC_EXT) || (i_keycode == SC_BRK);
  assign make_ev   = i_ready && !is_prefix && (state_q == ST_BASE);
  assign brk_ev    = i_ready && !is_prefix && (state_q == ST_BRK);
  // Translation sees modifier/lock state from before this byte.
  assign xlat      = kb_translate(i_keycode, lshift_q | rshift_q, led_q[LED_CAPS]);
  assign char_push = make_ev && xlat[8];

  always_comb begin
    state_d       = state_q;
    lshift_d      = lshift_q;
    rshift_d      = rshift_q;
    caps_held_d   = caps_held_q;
    num_held_d    = num_held_q;
    scroll_held_d = scroll_held_q;
    led_d         = led_q;

    if (i_ready) begin
      if (i_keycode == SC_EXT)
        state_d = ST_EXT;
      else if (i_keycode == SC_BRK)
        state_d = (state_q == ST_EXT) ? ST_EXT_BRK : ST_BRK;
      else
        state_d = ST_BASE;
    end

    if (make_ev || brk_ev) begin
      case (i_keycode)
        SC_LSHIFT: lshift_d = make_ev;
        SC_RSHIFT: rshift_d = make_ev;
        SC_CAPS: begin
          caps_held_d = make_ev;
          if (make_ev && !caps_held_q) led_d[LED_CAPS] = ~led_q[LED_CAPS];
        end
        SC_NUM: begin
          num_held_d = make_ev;
          if (make_ev && !num_held_q) led_d[LED_NUM] = ~led_q[LED_NUM];
        end
        SC_SCROLL: begin
          scroll_held_d = make_ev;
          if (make_ev && !scroll_held_q) led_d[LED_SCROLL] = ~led_q[LED_SCROLL];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= ST_BASE;
      lshift_q      <= 1'b0;
      rshift_q      <= 1'b0;
      caps_held_q   <= 1'b0;
      num_held_q    <= 1'b0;
      scroll_held_q <= 1'b0;
      led_q         <= 3'b000;
    end else begin
      state_q       <= state_d;
      lshift_q      <= lshift_d;
      rshift_q      <= rshift_d;
      caps_held_q   <= caps_held_d;
      num_held_q    <= num_held_d;
      scroll_held_q <= scroll_held_d;
      led_q         <= led_d;
    end
  end

  assign o_led_status = led_q;

  kb_char_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i      (i_clk),
    .rst_i      (i_reset),
    .push_i     (char_push),
    .data_i     (xlat[7:0]),
    .pop_i      (i_pop),
    .data_o     (o_ascii),
    .valid_o    (o_valid),
    .overflow_o (o_overflow)
  );

endmodule
`default_nettype wire

// File: doc/kb_decoder.md
KB_DECODER -- requirements
Module: kb_decoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, meaning the number of decoded-character entries buffered; legal values are powers of two, 2 to 16.
REQ-002 SHALL have port i_clk, input, 1, system clock; the block uses one clock, and this port is it.
REQ-003 SHALL have port i_reset, input, 1, reset; reset is synchronous and active-high.
REQ-004 SHALL have port i_keycode, input, 8, scan-code byte from the PS/2 receiver, valid while i_ready is high.
REQ-005 SHALL have port i_ready, input, 1, one-cycle strobe marking a new i_keycode.
REQ-006 SHALL have port o_led_status, output, 3, lock state: [0] Scroll, [1] Num, [2] Caps; feeds the receiver's LED-status input.
REQ-007 SHALL have port o_ascii, output, 8, ASCII character at the FIFO head (show-ahead).
REQ-008 SHALL have port o_valid, output, 1, high when the FIFO is not empty.
REQ-009 SHALL have port i_pop, input, 1, consumer acknowledge; it pops the head when o_valid is high.
REQ-010 SHALL have port o_overflow, output, 1, sticky flag: a character was dropped because the FIFO was full.

Function
REQ-011 SHALL implement a prefix FSM with states BASE, EXT, BRK and EXT_BRK, and SHALL advance only on cycles with i_ready=1.
REQ-012 SHALL make these prefix transitions:
- 0xE0 in any state -> EXT.
- 0xF0 in BASE -> BRK.
- 0xF0 in EXT -> EXT_BRK.
- 0xF0 in BRK or EXT_BRK -> BRK.
REQ-013 SHALL treat any non-prefix code as follows, then return to BASE:
- BASE: make event.
- BRK: break event.
- EXT or EXT_BRK: discard, with no side effects.
REQ-014 SHALL maintain shift = lshift_held OR rshift_held. Make 0x12 or 0x59 sets the corresponding held bit; break of the same code clears it.
REQ-015 SHALL toggle a lock bit on the make of 0x58 (Caps), 0x77 (Num) or 0x7E (Scroll) only when that key's held bit is 0. The make also sets the held bit and the break clears it, so typematic repeats do not re-toggle.
REQ-016 SHALL translate make codes to ASCII as follows:
- Letters 0x1C..0x1A (US set-2 map): uppercase iff shift XOR caps.
- Digits 0x16..0x45: the digit unshifted; US symbols "!@#$%^&*()" when shifted.
- 0x29 -> 0x20 (space); 0x5A -> 0x0D (enter); 0x66 -> 0x08 (backspace).
- All other make codes produce no character.
REQ-017 SHALL push the translated character at the same clock edge that registers the make event, so o_valid rises on cycle N+1 for an i_ready strobe on cycle N into an empty FIFO.
REQ-018 SHALL present o_led_status changes on cycle N+1 after the strobe of the toggling make code.
REQ-019 SHALL ignore i_pop when o_valid=0.
REQ-020 SHALL, on a push into a full FIFO without a simultaneous pop, drop the new character, leave the FIFO contents unchanged, and set o_overflow.
REQ-021 SHALL accept a push and a pop on the same cycle (including when the FIFO is full), leaving occupancy unchanged and preserving ordering.
REQ-022 SHALL let read and write pointers wrap modulo FIFO_DEPTH, with occupancy held in a log2(FIFO_DEPTH)+1 bit counter.

Reset
REQ-023 SHALL, when i_reset=1 at a rising edge, set: FSM=BASE; all held bits=0; lock bits=0 (o_led_status=3'b000); FIFO empty (o_valid=0); o_overflow=0; o_ascii=8'h00.
REQ-024 SHALL give reset priority over a coincident i_ready or i_pop; the byte and the pop are discarded, including mid-sequence (e.g. after 0xF0).

Structure
REQ-025 SHALL place the following in shared package kb_pkg:
- Scan-code constants (0xE0, 0xF0, shift, lock, space, enter and backspace codes).
- The FSM state encoding.
- The LED bit indices.
REQ-026 SHALL instantiate exactly one sub-module, kb_char_fifo (parameterised by FIFO_DEPTH), for character buffering; decoding and the FSM remain in kb_decoder.

Verification
REQ-027 Strobe 0x1C, then 0xF0, then 0x1C -> one entry 0x61 ('a'); o_valid rises one cycle after the first strobe; the break adds nothing.
REQ-028 Strobe 0x12, then 0x1C, then 0xF0, 0x12, then 0x1C -> entries 0x41 then 0x61.
REQ-029 Strobe 0x58 three times (typematic), then 0xF0, 0x58, then 0x58 -> o_led_status=3'b100 after the first strobe, unchanged through the repeats, 3'b000 after the final make; 0x1C under caps yields 0x41.
REQ-030 Strobe 0xE0, 0x75, then 0xE0, 0xF0, 0x75 -> no FIFO entry, state returns to BASE, next 0x16 yields 0x31.
REQ-031 With FIFO_DEPTH=4 and no pops, strobe five letter makes -> four entries retained in order, fifth dropped, o_overflow=1. Then a simultaneous pop and push on the full FIFO keeps occupancy at 4 with correct order.
REQ-032 Assert i_reset on the cycle after 0xF0 with the FIFO holding 2 entries -> o_valid=0 and o_led_status=0; the next 0x1C is treated as a make (0x61 pushed).
